// File: rtl/data_mem_responder_pkg.sv
// data_mem_pkg: shared address map and register bit positions for the data-memory responder.
// Latency: n/a (constants and a pure helper function only).
// Backpressure: n/a.
package data_mem_pkg;

  localparam logic [7:0] MMIO_BASE    = 8'hF0;
  localparam logic [7:0] ADDR_LED     = 8'hF0;
  localparam logic [7:0] ADDR_SW      = 8'hF1;
  localparam logic [7:0] ADDR_TMR_LO  = 8'hF2;
  localparam logic [7:0] ADDR_TMR_HI  = 8'hF3;
  localparam logic [7:0] ADDR_TMR_CTL = 8'hF4;
  localparam logic [7:0] ADDR_STATUS  = 8'hF5;

  // Bit positions inside TMR_CTL and STATUS.
  localparam int CTL_EN   = 0;
  localparam int CTL_CLR  = 1;
  localparam int STAT_OVF = 0;

  // Register index inside the 16-byte MMIO window.
  function automatic logic [3:0] mmio_idx(input logic [7:0] addr);
    return addr[3:0];
  endfunction

endpackage

// File: rtl/data_mem_responder_mmio_timer.sv
// mmio_timer: 16-bit free-running timer with coherent HI shadow, control and sticky overflow/irq.
// Latency: register writes land on the sampling edge; read data is combinational (top registers it).
// Backpressure: none; one access per cycle, clr beats increment, overflow set beats clear.
module mmio_timer
  import data_mem_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       wr,
  input  logic       rd,
  input  logic [3:0] idx,
  input  logic [1:0] wdat,
  output logic [7:0] rd_dat,
  output logic       irq
);

  localparam logic [3:0] IDX_LO   = mmio_idx(ADDR_TMR_LO);
  localparam logic [3:0] IDX_HI   = mmio_idx(ADDR_TMR_HI);
  localparam logic [3:0] IDX_CTL  = mmio_idx(ADDR_TMR_CTL);
  localparam logic [3:0] IDX_STAT = mmio_idx(ADDR_STATUS);

  logic [15:0] cnt_q, cnt_d;
  logic [7:0]  hi_q, hi_d;
  logic        en_q, en_d;
  logic        ovf_q, ovf_d;
  logic        wr_ctl, wr_stat, clr, wrap;

  // Next-state for counter, shadow, enable and sticky overflow.
  always_comb begin
    wr_ctl  = wr && (idx == IDX_CTL);
    wr_stat = wr && (idx == IDX_STAT);
    clr     = wr_ctl && wdat[CTL_CLR];
    wrap    = en_q && !clr && (cnt_q == 16'hFFFF);

    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = 16'h0000;
    end else if (en_q) begin
      cnt_d = cnt_q + 16'd1;
    end

    en_d = wr_ctl ? wdat[CTL_EN] : en_q;

    ovf_d = ovf_q;
    if (wrap) begin
      ovf_d = 1'b1;
    end else if (wr_stat && wdat[STAT_OVF]) begin
      ovf_d = 1'b0;
    end

    // Reading LO freezes the upper byte so a following HI read is coherent.
    hi_d = (rd && (idx == IDX_LO)) ? cnt_q[15:8] : hi_q;
  end

  // Read mux; R/W and write-1 bits return their post-write value.
  always_comb begin
    rd_dat = 8'h00;
    case (idx)
      IDX_LO:   rd_dat = cnt_q[7:0];
      IDX_HI:   rd_dat = hi_q;
      IDX_CTL:  rd_dat[CTL_EN] = en_d;
      IDX_STAT: rd_dat[STAT_OVF] = wr_stat ? ovf_d : ovf_q;
      default:  rd_dat = 8'h00;
    endcase
  end

  // Timer state registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q <= 16'h0000;
      hi_q  <= 8'h00;
      en_q  <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      hi_q  <= hi_d;
      en_q  <= en_d;
      ovf_q <= ovf_d;
    end
  end

  assign irq = ovf_q;

endmodule

// File: rtl/data_mem_responder.sv
// data_mem_responder: 240-byte data RAM plus LED/SW/timer MMIO at 0xF0-0xFF; timer only with DATA_MEM_TIMER_EN.
// Latency: q/q_valid registered, valid the cycle after MemRead; writes land on the sampling edge (write-first).
// Backpressure: none; accepts one request per cycle, requests in a reset cycle are dropped.
module data_mem_responder
  import data_mem_pkg::*;
#(
  parameter int RAM_WORDS   = 240,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       MemRead,
  input  logic       wren,
  input  logic [7:0] address,
  input  logic [7:0] data,
  output logic [7:0] q,
  output logic       q_valid,
  input  logic [2:0] sw,
  output logic [7:0] led,
  output logic       irq
);

  logic [7:0] mem_q [RAM_WORDS];
  logic       is_ram, ram_we, led_we;
  logic [7:0] led_q, led_d;
  logic [7:0] q_q, q_d;
  logic       q_valid_q, q_valid_d;
  logic [7:0] rd_dat, tmr_rd_dat;
  logic [SYNC_STAGES-1:0][2:0] sync_q, sync_d;
  logic [2:0] sw_sync;

  // Address decode and write enables; reset suppresses RAM writes.
  always_comb begin
    is_ram = (address < MMIO_BASE);
    ram_we = wren && is_ram && !reset;
    led_we = wren && (address == ADDR_LED);
  end

  // Data RAM; contents survive reset.
  always_ff @(posedge clock) begin
    if (ram_we) begin
      mem_q[address] <= data;
    end
  end

`ifdef DATA_MEM_TIMER_EN
  logic mmio_wr, mmio_rd;
  assign mmio_wr = wren && !is_ram;
  assign mmio_rd = MemRead && !is_ram;

  mmio_timer u_timer (
    .clock  (clock),
    .reset  (reset),
    .wr     (mmio_wr),
    .rd     (mmio_rd),
    .idx    (mmio_idx(address)),
    .wdat   (data[1:0]),
    .rd_dat (tmr_rd_dat),
    .irq    (irq)
  );
`else
  assign tmr_rd_dat = 8'h00;
  assign irq        = 1'b0;
`endif

  // Switch synchronizer shift chain; oldest stage feeds the SW register.
  always_comb begin
    sync_d[0] = sw;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
    sw_sync = sync_q[SYNC_STAGES-1];
  end

  // Read mux with write-first bypass for RAM and LED.
  always_comb begin
    rd_dat = 8'h00;
    if (is_ram) begin
      rd_dat = wren ? data : mem_q[address];
    end else begin
      case (address)
        ADDR_LED:     rd_dat = wren ? data : led_q;
        ADDR_SW:      rd_dat = {5'b00000, sw_sync};
        ADDR_TMR_LO,
        ADDR_TMR_HI,
        ADDR_TMR_CTL,
        ADDR_STATUS:  rd_dat = tmr_rd_dat;
        default:      rd_dat = 8'h00;
      endcase
    end
  end

  // Next-state for LED and the registered read port; q holds when idle.
  always_comb begin
    led_d     = led_we ? data : led_q;
    q_d       = MemRead ? rd_dat : q_q;
    q_valid_d = MemRead;
  end

  // LED, read port and synchronizer registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      led_q     <= 8'h00;
      q_q       <= 8'h00;
      q_valid_q <= 1'b0;
      sync_q    <= '0;
    end else begin
      led_q     <= led_d;
      q_q       <= q_d;
      q_valid_q <= q_valid_d;
      sync_q    <= sync_d;
    end
  end

  assign led     = led_q;
  assign q       = q_q;
  assign q_valid = q_valid_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: randomized and directed stimulus against a cycle-level reference model.
// Latency: checks q/q_valid one cycle after each request, sampled 1ns after the rising edge.
// Backpressure: n/a; one request per cycle, timer scenarios only in DATA_MEM_TIMER_EN builds.
module tb_data_mem_responder;

  logic       clock, reset, MemRead, wren;
  logic [7:0] address, data, q, led;
  logic       q_valid, irq;
  logic [2:0] sw;

  int vectors = 0;
  int errors  = 0;

  // Reference model state.
  logic [7:0]  m_ram [0:239];
  logic [7:0]  m_led = 8'h00;
  logic [7:0]  m_q   = 8'h00;
  logic        m_qv  = 1'b0;
  logic        m_ovf = 1'b0;
  logic [2:0]  swh [$];
`ifdef DATA_MEM_TIMER_EN
  logic [15:0] m_cnt = 16'h0000;
  logic [7:0]  m_hi  = 8'h00;
  logic        m_en  = 1'b0;
`endif

  data_mem_responder dut (
    .clock   (clock),
    .reset   (reset),
    .MemRead (MemRead),
    .wren    (wren),
    .address (address),
    .data    (data),
    .q       (q),
    .q_valid (q_valid),
    .sw      (sw),
    .led     (led),
    .irq     (irq)
  );

  always #5 clock = ~clock;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // One clock cycle: drive request, advance the model from the address-map rules.
  task automatic step(input logic rst, input logic rd, input logic wr,
                      input logic [7:0] a, input logic [7:0] d);
    logic [7:0] rv;
    logic       novf;
`ifdef DATA_MEM_TIMER_EN
    logic        nclr, nen;
    logic [15:0] ncnt;
`endif
    reset = rst; MemRead = rd; wren = wr; address = a; data = d;
    novf = m_ovf;
`ifdef DATA_MEM_TIMER_EN
    nclr = wr && a == 8'hF4 && d[1];
    nen  = (wr && a == 8'hF4) ? d[0] : m_en;
    ncnt = nclr ? 16'h0000 : (m_en ? m_cnt + 16'd1 : m_cnt);
    if (m_en && !nclr && m_cnt == 16'hFFFF) novf = 1'b1;
    else if (wr && a == 8'hF5 && d[0])      novf = 1'b0;
`endif
    if (a < 8'hF0) rv = wr ? d : m_ram[a];
    else if (a == 8'hF0) rv = wr ? d : m_led;
    else if (a == 8'hF1) rv = {5'b0, swh[0]};
`ifdef DATA_MEM_TIMER_EN
    else if (a == 8'hF2) rv = m_cnt[7:0];
    else if (a == 8'hF3) rv = m_hi;
    else if (a == 8'hF4) rv = {7'b0, nen};
    else if (a == 8'hF5) rv = {7'b0, wr ? novf : m_ovf};
`endif
    else rv = 8'h00;
    @(posedge clock);
    if (rst) begin
      m_q = 8'h00; m_qv = 1'b0; m_led = 8'h00; m_ovf = 1'b0;
      swh = '{3'b000, 3'b000};
`ifdef DATA_MEM_TIMER_EN
      m_cnt = 16'h0000; m_hi = 8'h00; m_en = 1'b0;
`endif
    end else begin
      if (rd) m_q = rv;
      m_qv = rd;
      if (wr && a < 8'hF0) m_ram[a] = d;
      if (wr && a == 8'hF0) m_led = d;
      void'(swh.pop_front());
      swh.push_back(sw);
      m_ovf = novf;
`ifdef DATA_MEM_TIMER_EN
      if (rd && a == 8'hF2) m_hi = m_cnt[15:8];
      m_cnt = ncnt;
      m_en  = nen;
`endif
    end
    #1;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++)
      step(1'b1, 1'b1, 1'b1, 8'(i + 8'h10), 8'($urandom));
    vectors++; if (q !== 8'h00)   begin errors++; $display("FAIL reset_q: got %h want 00", q); end
    vectors++; if (q_valid !== 1'b0) begin errors++; $display("FAIL reset_qv: got %b want 0", q_valid); end
    vectors++; if (led !== 8'h00) begin errors++; $display("FAIL reset_led: got %h want 00", led); end
    vectors++; if (irq !== 1'b0)  begin errors++; $display("FAIL reset_irq: got %b want 0", irq); end
  endtask

  task automatic test_back_to_back();
    for (int a = 0; a < 240; a++) step(1'b0, 1'b0, 1'b1, 8'(a), 8'($urandom));
    for (int a = 0; a < 240; a++) begin
      step(1'b0, 1'b1, 1'b0, 8'(a), 8'h00);
      vectors++;
      if (q !== m_q || q_valid !== 1'b1) begin
        errors++; $display("FAIL b2b_read[%0d]: got %h/%b want %h/1", a, q, q_valid, m_q);
      end
    end
  endtask

  task automatic test_ram_raw();
    step(1'b0, 1'b0, 1'b1, 8'h10, 8'h5A);
    vectors++; if (q_valid !== 1'b0) begin errors++; $display("FAIL raw_wr_qv: got %b want 0", q_valid); end
    step(1'b0, 1'b1, 1'b0, 8'h10, 8'h00);
    vectors++; if (q !== 8'h5A || q_valid !== 1'b1) begin
      errors++; $display("FAIL raw_10: got %h/%b want 5a/1", q, q_valid); end
    idle();
    vectors++; if (q !== 8'h5A || q_valid !== 1'b0) begin
      errors++; $display("FAIL raw_hold: got %h/%b want 5a/0", q, q_valid); end
    step(1'b0, 1'b0, 1'b1, 8'hEF, 8'hC3);
    step(1'b0, 1'b1, 1'b0, 8'hEF, 8'h00);
    vectors++; if (q !== 8'hC3) begin errors++; $display("FAIL raw_ef: got %h want c3", q); end
  endtask

  task automatic test_collision();
    step(1'b0, 1'b1, 1'b1, 8'h20, 8'h77);
    vectors++; if (q !== 8'h77) begin errors++; $display("FAIL coll_ram: got %h want 77", q); end
    step(1'b0, 1'b1, 1'b1, 8'hF0, 8'h77);
    vectors++; if (q !== 8'h77) begin errors++; $display("FAIL coll_led_q: got %h want 77", q); end
    vectors++; if (led !== 8'h77) begin errors++; $display("FAIL coll_led: got %h want 77", led); end
  endtask

  task automatic test_sw_sync();
    sw = 3'b010;
    repeat (3) idle();
    sw = 3'b101;
    step(1'b0, 1'b1, 1'b0, 8'hF1, 8'h00);
    vectors++; if (q !== m_q) begin errors++; $display("FAIL sw_early: got %h want %h", q, m_q); end
    idle();
    step(1'b0, 1'b1, 1'b0, 8'hF1, 8'h00);
    vectors++; if (q !== 8'h05) begin errors++; $display("FAIL sw_sync: got %h want 05", q); end
  endtask

  task automatic test_mmio_window();
    for (int a = 8'hF6; a <= 8'hFF; a++) step(1'b0, 1'b0, 1'b1, 8'(a), 8'hFF);
    for (int a = 8'hF2; a <= 8'hFF; a++) begin
      step(1'b0, 1'b1, 1'b0, 8'(a), 8'h00);
      vectors++;
      if (q !== m_q) begin errors++; $display("FAIL mmio_rd[%h]: got %h want %h", a, q, m_q); end
`ifndef DATA_MEM_TIMER_EN
      vectors++;
      if (q !== 8'h00) begin errors++; $display("FAIL mmio_zero[%h]: got %h want 00", a, q); end
`endif
    end
  endtask

`ifdef DATA_MEM_TIMER_EN
  task automatic test_timer_coherence();
    int n = 0;
    step(1'b0, 1'b0, 1'b1, 8'hF4, 8'h03);
    while (m_cnt != 16'h12FF && n < 70000) begin idle(); n++; end
    vectors++; if (m_cnt != 16'h12FF) begin errors++; $display("FAIL tmr_reach: cnt %h want 12ff", m_cnt); end
    step(1'b0, 1'b1, 1'b0, 8'hF2, 8'h00);
    vectors++; if (q !== 8'hFF) begin errors++; $display("FAIL tmr_lo: got %h want ff", q); end
    repeat (5) idle();
    step(1'b0, 1'b1, 1'b0, 8'hF3, 8'h00);
    vectors++; if (q !== 8'h12) begin errors++; $display("FAIL tmr_hi: got %h want 12", q); end
  endtask

  task automatic test_overflow();
    int n = 0;
    while (m_cnt != 16'hFFFF && n < 70000) begin idle(); n++; end
    vectors++; if (irq !== 1'b0) begin errors++; $display("FAIL ovf_pre: irq %b want 0", irq); end
    step(1'b0, 1'b0, 1'b1, 8'hF5, 8'h01);
    vectors++; if (irq !== 1'b1) begin errors++; $display("FAIL ovf_set_wins: irq %b want 1", irq); end
    step(1'b0, 1'b1, 1'b0, 8'hF5, 8'h00);
    vectors++; if (q !== 8'h01) begin errors++; $display("FAIL ovf_status: got %h want 01", q); end
    step(1'b0, 1'b0, 1'b1, 8'hF5, 8'h01);
    vectors++; if (irq !== 1'b0) begin errors++; $display("FAIL ovf_clear: irq %b want 0", irq); end
  endtask
`endif

  task automatic test_reset_mid();
    step(1'b0, 1'b0, 1'b1, 8'hF0, 8'hA5);
    step(1'b0, 1'b0, 1'b1, 8'h10, 8'h5A);
`ifdef DATA_MEM_TIMER_EN
    step(1'b0, 1'b0, 1'b1, 8'hF4, 8'h01);
`endif
    step(1'b0, 1'b1, 1'b0, 8'h10, 8'h00);
    step(1'b1, 1'b1, 1'b1, 8'h10, 8'h99);
    vectors++; if (q !== 8'h00 || q_valid !== 1'b0) begin
      errors++; $display("FAIL rmid_q: got %h/%b want 00/0", q, q_valid); end
    vectors++; if (led !== 8'h00 || irq !== 1'b0) begin
      errors++; $display("FAIL rmid_led_irq: got %h/%b want 00/0", led, irq); end
    step(1'b0, 1'b1, 1'b0, 8'h10, 8'h00);
    vectors++; if (q !== 8'h5A) begin errors++; $display("FAIL rmid_ram: got %h want 5a", q); end
`ifdef DATA_MEM_TIMER_EN
    step(1'b0, 1'b1, 1'b0, 8'hF2, 8'h00);
    vectors++; if (q !== 8'h00) begin errors++; $display("FAIL rmid_cnt: got %h want 00", q); end
`endif
  endtask

  task automatic test_random();
    logic [7:0] a;
    for (int i = 0; i < 600; i++) begin
      sw = 3'($urandom);
      a  = ($urandom_range(0, 9) < 7) ? 8'($urandom_range(0, 239)) : 8'($urandom_range(240, 255));
      step(1'b0, 1'($urandom), 1'($urandom), a, 8'($urandom));
      vectors++;
      if (q !== m_q || q_valid !== m_qv) begin
        errors++; $display("FAIL rand_q[%0d]: got %h/%b want %h/%b", i, q, q_valid, m_q, m_qv); end
      vectors++;
      if (led !== m_led) begin errors++; $display("FAIL rand_led[%0d]: got %h want %h", i, led, m_led); end
      vectors++;
      if (irq !== m_ovf) begin errors++; $display("FAIL rand_irq[%0d]: got %b want %b", i, irq, m_ovf); end
    end
  endtask

  initial begin
    clock = 1'b0; reset = 1'b1; MemRead = 1'b0; wren = 1'b0;
    address = 8'h00; data = 8'h00; sw = 3'b000;
    swh = '{3'b000, 3'b000};
    for (int i = 0; i < 240; i++) m_ram[i] = 8'h00;
    test_reset();
    test_back_to_back();
    test_ram_raw();
    test_collision();
    test_sw_sync();
    test_mmio_window();
`ifdef DATA_MEM_TIMER_EN
    test_timer_coherence();
    test_overflow();
`endif
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
